// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : UART MMIO register map, bit indices and feeder FSM states.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [31:0] c_ofs_tx     = 32'h0000_0000;
  localparam logic [31:0] c_ofs_rx     = 32'h0000_0004;
  localparam logic [31:0] c_ofs_status = 32'h0000_0008;
  localparam logic [31:0] c_ofs_ctrl   = 32'h0000_000C;
  localparam logic [31:0] c_ofs_baud   = 32'h0000_0010;

  localparam int c_status_rx_valid_bit = 0;
  localparam int c_status_tx_ready_bit = 1;

  localparam int c_ctrl_en_bit = 2;

  typedef enum logic [2:0] {
    ST_INIT_BAUD   = 3'd0,
    ST_INIT_CTRL   = 3'd1,
    ST_IDLE        = 3'd2,
    ST_RD_STATUS   = 3'd3,
    ST_WAIT_STATUS = 3'd4,
    ST_WR_TX       = 3'd5,
    ST_WAIT_TX     = 3'd6,
    ST_BACKOFF     = 3'd7
  } feeder_state_t;

  // CTRL word that turns the UART on
  function automatic logic [31:0] ctrl_enable_word();
    logic [31:0] v;
    v = 32'h0;
    v[c_ctrl_en_bit] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_byte_fifo                                               |
// | Description : Byte FIFO, power-of-two depth, first-word-fall-through head. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  resetn,
  input  logic  push,
  input  byte_t wdata,
  input  logic  pop,
  output byte_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int                 c_aw         = $clog2(DEPTH);
  localparam logic [c_aw:0]      c_full_count = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0]      c_one_cnt    = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0]    c_one_ptr    = c_aw'(1);

  byte_t             r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == c_full_count);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_one_ptr;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_one_ptr;
      // a simultaneous push and pop leaves the occupancy untouched
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one_cnt;
        2'b01:   r_count <= r_count - c_one_cnt;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_feeder                                               |
// | Description : Buffers upstream bytes and writes them to a UART over MMIO,  |
// |               polling STATUS for TX space. Optional UART init sequence is  |
// |               compiled in with macro UART_FEEDER_INIT_EN.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter logic [31:0] UART_BASE    = 32'h8000_1000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          POLL_GAP     = 4,
  parameter int          RESP_TIMEOUT = 16,
  parameter logic [31:0] BAUD_DIV     = 32'd868
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err_timeout,
  input  logic        err_clr
);

`ifdef UART_FEEDER_INIT_EN
  localparam bit c_init_en = 1'b1;
`else
  localparam bit c_init_en = 1'b0;
`endif

  localparam feeder_state_t c_reset_state = c_init_en ? ST_INIT_BAUD : ST_IDLE;

  localparam int            c_tw        = $clog2(RESP_TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_to_last = c_tw'(RESP_TIMEOUT - 1);
  localparam logic [c_tw-1:0] c_to_one  = c_tw'(1);
  localparam int            c_gw        = $clog2(POLL_GAP + 1);
  localparam logic [c_gw-1:0] c_gap_last = c_gw'(POLL_GAP - 1);
  localparam logic [c_gw-1:0] c_gap_one  = c_gw'(1);

  feeder_state_t     r_state;
  feeder_state_t     w_state_nxt;
  logic [c_tw-1:0]   r_wait_cnt;
  logic [c_gw-1:0]   r_gap_cnt;
  logic              r_req_sent;
  logic              r_init_done;
  logic              r_err;

  logic              w_full;
  logic              w_empty;
  byte_t             w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_in_wait;
  logic              w_expired;
  logic              w_valid;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_wstrb;
  logic              w_unused_rdata;

  assign w_unused_rdata = ^{mem_rdata[31:2], mem_rdata[0]};

  assign s_ready = resetn && r_init_done && !w_full;
  assign w_push  = s_valid && s_ready;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .wdata  (s_data),
    .pop    (w_pop),
    .rdata  (w_head),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign w_in_wait = (r_state == ST_WAIT_STATUS) || (r_state == ST_WAIT_TX) ||
                     (((r_state == ST_INIT_BAUD) || (r_state == ST_INIT_CTRL)) && r_req_sent);
  assign w_expired = w_in_wait && !mem_ready && (r_wait_cnt == c_to_last);

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_addr      = 32'h0;
    w_wdata     = 32'h0;
    w_wstrb     = 4'h0;
    w_pop       = 1'b0;
    case (r_state)
      ST_INIT_BAUD: begin
        if (!r_req_sent) begin
          w_valid = 1'b1;
          w_addr  = UART_BASE + c_ofs_baud;
          w_wdata = BAUD_DIV;
          w_wstrb = 4'b1111;
        end else if (mem_ready) begin
          w_state_nxt = ST_INIT_CTRL;
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_INIT_CTRL: begin
        if (!r_req_sent) begin
          w_valid = 1'b1;
          w_addr  = UART_BASE + c_ofs_ctrl;
          w_wdata = ctrl_enable_word();
          w_wstrb = 4'b0001;
        end else if (mem_ready || w_expired) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!w_empty) w_state_nxt = ST_RD_STATUS;
      end
      ST_RD_STATUS: begin
        w_valid     = 1'b1;
        w_addr      = UART_BASE + c_ofs_status;
        w_state_nxt = ST_WAIT_STATUS;
      end
      ST_WAIT_STATUS: begin
        if (mem_ready) begin
          w_state_nxt = mem_rdata[c_status_tx_ready_bit] ? ST_WR_TX : ST_BACKOFF;
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR_TX: begin
        w_valid     = 1'b1;
        w_addr      = UART_BASE + c_ofs_tx;
        w_wdata     = {24'h0, w_head};
        w_wstrb     = 4'b0001;
        w_state_nxt = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // the head byte leaves the FIFO only once its write is acknowledged
        if (mem_ready) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BACKOFF: begin
        if (r_gap_cnt == c_gap_last) w_state_nxt = ST_RD_STATUS;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= c_reset_state;
      r_wait_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_req_sent  <= 1'b0;
      r_init_done <= !c_init_en;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= (w_in_wait && (w_state_nxt == r_state)) ? r_wait_cnt + c_to_one : '0;
      r_gap_cnt   <= ((r_state == ST_BACKOFF) && (w_state_nxt == ST_BACKOFF)) ?
                     r_gap_cnt + c_gap_one : '0;
      r_req_sent  <= (w_state_nxt == r_state) && (r_req_sent || w_valid);
      r_init_done <= r_init_done || (w_state_nxt == ST_IDLE);
      // a timeout in the same cycle as err_clr keeps the flag set
      if (w_expired)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign mem_valid   = resetn && w_valid;
  assign mem_addr    = resetn ? w_addr  : 32'h0;
  assign mem_wdata   = resetn ? w_wdata : 32'h0;
  assign mem_wstrb   = resetn ? w_wstrb : 4'h0;
  assign mem_instr   = 1'b0;
  assign busy        = resetn && (!w_empty || (r_state != ST_IDLE));
  assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_feeder                                            |
// | Description : Scoreboard bench for uart_tx_feeder with an MMIO slave model.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_feeder;

  localparam logic [31:0] c_base = 32'h8000_1000;
  localparam int          c_gap  = 4;
  localparam int          c_tmo  = 16;
`ifdef UART_FEEDER_INIT_EN
  localparam int c_init_writes = 2;
`else
  localparam int c_init_writes = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h0;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  uart_tx_feeder dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .mem_valid   (mem_valid),
    .mem_instr   (mem_instr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  bus_t exp_q[$];

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_t e;
    e.addr = a; e.wdata = d; e.wstrb = s;
    exp_q.push_back(e);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    expect_wr(c_base, {24'h0, b}, 4'b0001);
  endtask

  task automatic expect_init();
    if (c_init_writes != 0) begin
      expect_wr(c_base + 32'h10, 32'h0000_0364, 4'b1111);
      expect_wr(c_base + 32'h0C, 32'h0000_0004, 4'b0001);
    end
  endtask

  // slave model state
  logic [31:0] status_q[$];
  logic [31:0] status_default = 32'h2;
  int          withhold_tx = 0;
  bit          resp_due = 0, resp_is_stat = 0, resp_is_tx = 0, outstanding = 0;
  logic [31:0] resp_data = 32'h0;
  bit          prev_valid = 0, gap_armed = 0, ack_tx = 0;
  int          n_valid = 0, n_stat = 0, n_tx = 0, inv_err = 0;
  int          last_tx_cyc = 0, stat_ack_cyc = 0;

  // slave responder and write monitor: one cycle of latency
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      if (mem_instr !== 1'b0) inv_err++;
      if (mem_valid) begin
        if (prev_valid || outstanding) inv_err++;
      end else if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
        inv_err++;
      end
      prev_valid = mem_valid;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      ack_tx = 1'b0;
      if (!resetn) begin
        resp_due = 0; outstanding = 0; gap_armed = 0;
      end else begin
        if (resp_due) begin
          mem_ready = 1'b1;
          mem_rdata = resp_data;
          resp_due = 0;
          outstanding = 0;
          if (resp_is_stat) begin
            stat_ack_cyc = cyc;
            gap_armed = !resp_data[1];
          end
          ack_tx = resp_is_tx;
        end
        if (mem_valid) begin
          n_valid++;
          if (mem_wstrb == 4'h0) begin
            n_stat++;
            if (mem_addr !== c_base + 32'h8) inv_err++;
            if (gap_armed) chk("poll_gap", 64'(cyc - stat_ack_cyc), 64'(c_gap + 1));
            gap_armed = 0;
            if (status_q.size() > 0) resp_data = status_q.pop_front();
            else resp_data = status_default;
            resp_is_stat = 1; resp_is_tx = 0; resp_due = 1; outstanding = 1;
          end else begin
            if (mem_addr == c_base) begin
              n_tx++;
              last_tx_cyc = cyc;
            end
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("wr_addr",  64'(mem_addr),  64'(e.addr));
              chk("wr_data",  64'(mem_wdata), 64'(e.wdata));
              chk("wr_strb",  64'(mem_wstrb), 64'(e.wstrb));
            end
            if (withhold_tx > 0 && mem_addr == c_base) begin
              withhold_tx--;
            end else begin
              resp_data = 32'h0;
              resp_is_stat = 0; resp_is_tx = (mem_addr == c_base);
              resp_due = 1; outstanding = 1;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, output bit ok);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 300) begin
      step();
      n++;
    end
    ok = s_ready;
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    chk(nm, 64'(busy), 64'd0);
  endtask

  task automatic wait_ack(input string nm, input bit need_ready);
    int n;
    n = 0;
    while (!(ack_tx && (s_ready || !need_ready)) && n < 500) begin
      step();
      n++;
    end
    chk(nm, 64'(ack_tx), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    int s0, t0, n0, cnt, n;

    // reset state
    repeat (3) step();
    chk("rst_s_ready",   64'(s_ready),     64'd0);
    chk("rst_mem_valid", 64'(mem_valid),   64'd0);
    chk("rst_busy",      64'(busy),        64'd0);
    chk("rst_err",       64'(err_timeout), 64'd0);
    chk("rst_mem_addr",  64'(mem_addr),    64'd0);
    expect_init();
    resetn = 1'b1;
    step();
    chk("s_ready_after_reset", 64'(s_ready), (c_init_writes == 0) ? 64'd1 : 64'd0);

    // single byte, UART ready on first poll
    s0 = n_stat;
    expect_byte(8'h41);
    push(8'h41, ok);
    chk("t1_push", 64'(ok), 64'd1);
    wait_ack("t1_ack", 1'b0);
    chk("t1_busy_at_ack", 64'(busy), 64'd1);
    step();
    chk("t1_busy_drop", 64'(busy), 64'd0);
    chk("t1_status_reads", 64'(n_stat - s0), 64'd1);

    // three not-ready polls, then ready
    s0 = n_stat;
    t0 = n_tx;
    status_q.push_back(32'h0);
    status_q.push_back(32'h0);
    status_q.push_back(32'h0);
    status_q.push_back(32'h2);
    expect_byte(8'h5A);
    push(8'h5A, ok);
    wait_idle("t2_idle");
    chk("t2_polls",     64'(n_stat - s0), 64'd4);
    chk("t2_tx_writes", 64'(n_tx - t0),   64'd1);

    // fill the FIFO while the UART reports no space
    status_default = 32'h0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      expect_byte(8'h10 + 8'(i));
      push(8'h10 + 8'(i), ok);
      cnt += int'(ok);
    end
    chk("t3_accepted8", 64'(cnt), 64'd8);
    chk("t3_full_s_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b1;
    s_data  = 8'h18;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (s_ready) n++;
      step();
    end
    chk("t3_no_accept_when_full", 64'(n), 64'd0);
    expect_byte(8'h18);
    status_default = 32'h2;
    push(8'h18, ok);
    chk("t3_ninth_push", 64'(ok), 64'd1);
    // push lands on the same edge as a pop with 7 entries held
    wait_ack("t3_pop_with_room", 1'b1);
    expect_byte(8'h19);
    push(8'h19, ok);
    expect_byte(8'h1A);
    push(8'h1A, ok);
    chk("t3_full_after_pushpop", 64'(s_ready), 64'd0);
    wait_idle("t3_idle");

    // TX write never acknowledged: timeout, then retry of the same byte
    t0 = n_tx;
    withhold_tx = 1;
    expect_byte(8'h55);
    expect_byte(8'h55);
    push(8'h55, ok);
    n = 0;
    while (!err_timeout && n < 200) begin
      step();
      n++;
    end
    chk("t4_timeout_latency", 64'(cyc - last_tx_cyc), 64'(c_tmo + 1));
    wait_idle("t4_idle");
    chk("t4_retry_writes", 64'(n_tx - t0), 64'd2);
    chk("t4_err_sticky", 64'(err_timeout), 64'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_err_cleared", 64'(err_timeout), 64'd0);

    // err_clr held through a timeout: the timeout wins
    withhold_tx = 1;
    expect_byte(8'h66);
    expect_byte(8'h66);
    err_clr = 1'b1;
    push(8'h66, ok);
    n = 0;
    while (!err_timeout && n < 200) begin
      step();
      n++;
    end
    chk("t4b_timeout_wins", 64'(cyc - last_tx_cyc), 64'(c_tmo + 1));
    step();
    chk("t4b_clr_next", 64'(err_timeout), 64'd0);
    err_clr = 1'b0;
    wait_idle("t4b_idle");

    // reset while a TX write is outstanding
    withhold_tx = 1;
    t0 = n_tx;
    expect_byte(8'h71);
    push(8'h71, ok);
    push(8'h72, ok);
    push(8'h73, ok);
    n = 0;
    while (n_tx == t0 && n < 200) begin
      step();
      n++;
    end
    step();
    resetn = 1'b0;
    expect_init();
    step();
    chk("t5_rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("t5_rst_s_ready",   64'(s_ready),   64'd0);
    step();
    chk("t5_rst_busy", 64'(busy), 64'd0);
    withhold_tx = 0;
    n0 = n_valid;
    resetn = 1'b1;
    repeat (30) step();
    chk("t5_no_bus_activity", 64'(n_valid - n0), 64'(c_init_writes));
    chk("t5_fifo_empty", 64'(busy), 64'd0);
    expect_byte(8'h7E);
    push(8'h7E, ok);
    wait_idle("t5_resume");

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("bus_invariants", 64'(inv_err), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
